// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle ack /
// frame_err pulses. A stop bit of 0 parks the FSM in BREAK until the line recovers.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       ack,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  // Counter values reached on the cycle before a sample point.
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  sync_q;
  logic        rx_s;
  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        ack_q;
  logic        ferr_q;

  // NOTE: synchronizer resets to 1 (line idle) so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  // NOTE: every register below uses <= so all next-state values derive from the same pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s) state_q <= ST_START;
        end
        ST_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              state_q <= ST_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              data_q  <= shift_q;
              ack_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_BREAK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out  = data_q;
  assign ack       = ack_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
